// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle of signals between the five-stage pipeline and its stall/flush
// scheduler.
//   master : pipeline side. Drives the ID/EXE/MEM observations and the
//            memory handshake, and receives the freeze/flush controls and
//            the statistics.
//   slave  : scheduler side (pipeline_hazard_ctrl).
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    // pipeline -> scheduler
    logic                  fwd_en;
    logic [REG_ADDR_W-1:0] id_src_1;
    logic [REG_ADDR_W-1:0] id_src_2;
    logic                  id_use_src_1;
    logic                  id_use_src_2;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  exe_wb_en;
    logic                  exe_mem_r_en;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_wb_en;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  clr_stats;

    // scheduler -> pipeline
    logic                  pc_freeze;
    logic                  if_freeze;
    logic                  id_freeze;
    logic                  exe_freeze;
    logic                  mem_freeze;
    logic                  if_flush;
    logic                  id_flush;
    logic                  hazard;
    logic [CNT_W-1:0]      hazard_cycles;
    logic [CNT_W-1:0]      mem_wait_cycles;
    logic [CNT_W-1:0]      flush_count;
    logic                  mem_err;

    modport master (
        output fwd_en, id_src_1, id_src_2, id_use_src_1, id_use_src_2,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, clr_stats,
        input  pc_freeze, if_freeze, id_freeze, exe_freeze, mem_freeze,
               if_flush, id_flush, hazard, hazard_cycles, mem_wait_cycles,
               flush_count, mem_err
    );

    modport slave (
        input  fwd_en, id_src_1, id_src_2, id_use_src_1, id_use_src_2,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               branch_taken, mem_req, mem_ready, clr_stats,
        output pc_freeze, if_freeze, id_freeze, exe_freeze, mem_freeze,
               if_flush, id_flush, hazard, hazard_cycles, mem_wait_cycles,
               flush_count, mem_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush scheduler for the five-stage pipeline.
//
// Ports
//   clk     : pipeline clock, rising edge
//   rst_n   : asynchronous active-low reset
//   io_bus  : pipeline_hazard_ctrl_if.slave
//             inputs  - ID sources, EXE/MEM destinations, branch decision,
//                       data-memory handshake, forwarding mode, stats clear
//             outputs - stage freezes/flushes, hazard flag, saturating
//                       statistics, sticky memory-timeout flag
//
// State | Meaning
// ------+--------------------------------------------------------------
// RUN   | normal issue; data hazards and branches are resolved here
// MEM_WAIT | data memory is stalling the MEM stage; whole pipe frozen
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave io_bus
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    // The edge that closes the MEM_TIMEOUT-th wait cycle is the one that
    // sees the counter one below the limit.
    localparam logic [WAIT_W-1:0] WAIT_HIT = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_hazard_cycles;
    logic [CNT_W-1:0]  r_mem_wait_cycles;
    logic [CNT_W-1:0]  r_flush_count;

    logic [REG_ADDR_W-1:0] w_src_1;
    logic [REG_ADDR_W-1:0] w_src_2;
    logic                  w_mstall;
    logic                  w_haz_1;
    logic                  w_haz_2;
    logic                  w_data_haz;
    logic                  w_freeze_all;
    logic                  w_freeze_front;
    logic                  w_if_flush;
    logic                  w_id_flush;
    logic                  w_hazard;

    assign w_src_1  = io_bus.id_src_1;
    assign w_src_2  = io_bus.id_src_2;
    assign w_mstall = io_bus.mem_req & ~io_bus.mem_ready;

    // With forwarding only a load in EXE cannot be bypassed; without it any
    // pending write in EXE or MEM blocks the read.
    always_comb begin
        w_haz_1 = 1'b0;
        w_haz_2 = 1'b0;
        if (io_bus.fwd_en) begin
            w_haz_1 = (w_src_1 == io_bus.exe_dest) & io_bus.exe_wb_en & io_bus.exe_mem_r_en;
            w_haz_2 = (w_src_2 == io_bus.exe_dest) & io_bus.exe_wb_en & io_bus.exe_mem_r_en;
        end else begin
            w_haz_1 = ((w_src_1 == io_bus.exe_dest) & io_bus.exe_wb_en) |
                      ((w_src_1 == io_bus.mem_dest) & io_bus.mem_wb_en);
            w_haz_2 = ((w_src_2 == io_bus.exe_dest) & io_bus.exe_wb_en) |
                      ((w_src_2 == io_bus.mem_dest) & io_bus.mem_wb_en);
        end
        w_haz_1 = w_haz_1 & io_bus.id_use_src_1;
        w_haz_2 = w_haz_2 & io_bus.id_use_src_2;
    end

    assign w_data_haz = w_haz_1 | w_haz_2;

    // A branch seen during a memory stall is held in EXE by the freeze, so
    // it is naturally flushed in the first cycle the stall drops.
    always_comb begin
        w_freeze_all   = 1'b0;
        w_freeze_front = 1'b0;
        w_if_flush     = 1'b0;
        w_id_flush     = 1'b0;
        w_hazard       = 1'b0;
        if (w_mstall) begin
            w_freeze_all = 1'b1;
        end else if (io_bus.branch_taken) begin
            w_if_flush = 1'b1;
            w_id_flush = 1'b1;
        end else if (w_data_haz) begin
            w_freeze_front = 1'b1;
            w_id_flush     = 1'b1;
            w_hazard       = 1'b1;
        end
    end

    // Controls are forced low while reset is held, whatever the inputs do.
    assign io_bus.pc_freeze  = rst_n & (w_freeze_all | w_freeze_front);
    assign io_bus.if_freeze  = rst_n & (w_freeze_all | w_freeze_front);
    assign io_bus.id_freeze  = rst_n & w_freeze_all;
    assign io_bus.exe_freeze = rst_n & w_freeze_all;
    assign io_bus.mem_freeze = rst_n & w_freeze_all;
    assign io_bus.if_flush   = rst_n & w_if_flush;
    assign io_bus.id_flush   = rst_n & w_id_flush;
    assign io_bus.hazard     = rst_n & w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_wait_cnt <= '0;
                if (w_mstall) begin
                    r_state <= ST_MEM_WAIT;
                end
            end else begin
                // ready or an abandoned request both end the wait
                if (!w_mstall) begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end else if (r_wait_cnt != WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
            end

            if (io_bus.clr_stats) begin
                r_mem_err <= 1'b0;
            end else if ((r_state == ST_MEM_WAIT) && w_mstall && (r_wait_cnt >= WAIT_HIT)) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hazard_cycles   <= '0;
            r_mem_wait_cycles <= '0;
            r_flush_count     <= '0;
        end else if (io_bus.clr_stats) begin
            r_hazard_cycles   <= '0;
            r_mem_wait_cycles <= '0;
            r_flush_count     <= '0;
        end else begin
            if (w_hazard && (r_hazard_cycles != '1)) begin
                r_hazard_cycles <= r_hazard_cycles + CNT_W'(1);
            end
            if (w_mstall && (r_mem_wait_cycles != '1)) begin
                r_mem_wait_cycles <= r_mem_wait_cycles + CNT_W'(1);
            end
            if (w_if_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign io_bus.hazard_cycles   = r_hazard_cycles;
    assign io_bus.mem_wait_cycles = r_mem_wait_cycles;
    assign io_bus.flush_count     = r_flush_count;
    assign io_bus.mem_err         = r_mem_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Bench for pipeline_hazard_ctrl built with MEM_TIMEOUT = 3.
// Control vector layout used throughout:
//   [7] pc_freeze [6] if_freeze [5] id_freeze [4] exe_freeze [3] mem_freeze
//   [2] if_flush  [1] id_flush  [0] hazard
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TO    = 3;
    localparam int CMAX  = 65535;

    localparam logic [7:0] C_NONE  = 8'h00;
    localparam logic [7:0] C_MST   = 8'hF8;
    localparam logic [7:0] C_BR    = 8'h06;
    localparam logic [7:0] C_HAZ   = 8'hC3;

    typedef struct {
        logic       fwd_en;
        logic [3:0] src1;
        logic       use1;
        logic [3:0] src2;
        logic       use2;
        logic [3:0] exe_dest;
        logic       exe_wb;
        logic       exe_rd;
        logic [3:0] mem_dest;
        logic       mem_wb;
        logic       br;
        logic       req;
        logic       rdy;
        logic       clr;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) hif ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (4),
        .CNT_W      (16),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int m_hz, m_mw, m_fc, m_run;
    bit m_err;

    logic [7:0]  dut_ctrl;
    logic [48:0] dut_stats;
    assign dut_ctrl  = {hif.pc_freeze, hif.if_freeze, hif.id_freeze, hif.exe_freeze,
                        hif.mem_freeze, hif.if_flush, hif.id_flush, hif.hazard};
    assign dut_stats = {hif.hazard_cycles, hif.mem_wait_cycles, hif.flush_count, hif.mem_err};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic in_t mk(bit fwd, int s1, bit u1, int s2, bit u2, int ed, bit ewb,
                               bit erd, int md, bit mwb, bit br, bit req, bit rdy);
        in_t v;
        v.fwd_en = fwd; v.src1 = 4'(s1); v.use1 = u1; v.src2 = 4'(s2); v.use2 = u2;
        v.exe_dest = 4'(ed); v.exe_wb = ewb; v.exe_rd = erd;
        v.mem_dest = 4'(md); v.mem_wb = mwb; v.br = br; v.req = req; v.rdy = rdy;
        v.clr = 1'b0;
        return v;
    endfunction

    function automatic bit src_haz(in_t v, bit use_s, logic [3:0] s);
        if (!use_s) return 1'b0;
        if (v.fwd_en) return (s == v.exe_dest) && v.exe_wb && v.exe_rd;
        return ((s == v.exe_dest) && v.exe_wb) || ((s == v.mem_dest) && v.mem_wb);
    endfunction

    function automatic logic [7:0] model_ctrl(in_t v);
        if (v.req && !v.rdy) return C_MST;
        if (v.br) return C_BR;
        if (src_haz(v, v.use1, v.src1) || src_haz(v, v.use2, v.src2)) return C_HAZ;
        return C_NONE;
    endfunction

    function automatic logic [48:0] model_stats();
        return {16'(m_hz), 16'(m_mw), 16'(m_fc), m_err};
    endfunction

    task automatic model_reset();
        m_hz = 0; m_mw = 0; m_fc = 0; m_run = 0; m_err = 0;
    endtask

    // one clock edge of the model: mem_err is set once the stall run length
    // covers the entry cycle plus TO wait cycles
    task automatic model_tick(in_t v);
        logic [7:0] e;
        bit mst;
        e   = model_ctrl(v);
        mst = v.req && !v.rdy;
        m_run = mst ? m_run + 1 : 0;
        if (v.clr) begin
            m_hz = 0; m_mw = 0; m_fc = 0; m_err = 0;
        end else begin
            if (e[0] && m_hz < CMAX) m_hz++;
            if (mst && m_mw < CMAX)  m_mw++;
            if (e[2] && m_fc < CMAX) m_fc++;
            if (m_run >= TO + 1) m_err = 1;
        end
    endtask

    task automatic drive(in_t v);
        hif.fwd_en       = v.fwd_en;
        hif.id_src_1     = v.src1;
        hif.id_use_src_1 = v.use1;
        hif.id_src_2     = v.src2;
        hif.id_use_src_2 = v.use2;
        hif.exe_dest     = v.exe_dest;
        hif.exe_wb_en    = v.exe_wb;
        hif.exe_mem_r_en = v.exe_rd;
        hif.mem_dest     = v.mem_dest;
        hif.mem_wb_en    = v.mem_wb;
        hif.branch_taken = v.br;
        hif.mem_req      = v.req;
        hif.mem_ready    = v.rdy;
        hif.clr_stats    = v.clr;
    endtask

    // called just after a rising edge; checks mid-cycle, advances one edge
    task automatic run_cycle(in_t v, logic [7:0] exp_ctrl, string nm);
        drive(v);
        @(negedge clk);
        chk({nm, "_ctrl"}, 64'(dut_ctrl), 64'(exp_ctrl));
        chk({nm, "_stats"}, 64'(dut_stats), 64'(model_stats()));
        @(posedge clk);
        model_tick(v);
        #1;
    endtask

    task automatic run_model(in_t v, string nm);
        run_cycle(v, model_ctrl(v), nm);
    endtask

    vec_t tbl[12];
    in_t  idle, v, stall, clr_v;

    initial begin
        idle  = mk(0, 0,0, 0,0, 0,0,0, 0,0, 0, 0,0);
        stall = idle; stall.req = 1'b1;
        clr_v = idle; clr_v.clr = 1'b1;

        tbl[0]  = '{"load_use",       mk(1, 3,1, 0,0, 3,1,1, 0,0, 0, 0,0), C_HAZ};
        tbl[1]  = '{"load_retired",   mk(1, 3,1, 0,0, 3,0,0, 3,1, 0, 0,0), C_NONE};
        tbl[2]  = '{"exe_not_load",   mk(1, 3,1, 0,0, 3,1,0, 0,0, 0, 0,0), C_NONE};
        tbl[3]  = '{"nofwd_mem",      mk(0, 0,0, 5,1, 9,0,0, 5,1, 0, 0,0), C_HAZ};
        tbl[4]  = '{"nofwd_unused",   mk(0, 0,0, 5,0, 9,0,0, 5,1, 0, 0,0), C_NONE};
        tbl[5]  = '{"nofwd_mem_wb0",  mk(0, 0,0, 5,1, 9,0,0, 5,0, 0, 0,0), C_NONE};
        tbl[6]  = '{"nofwd_exe",      mk(0, 7,1, 0,0, 7,1,0, 2,0, 0, 0,0), C_HAZ};
        tbl[7]  = '{"branch_prio",    mk(1, 3,1, 0,0, 3,1,1, 0,0, 1, 0,0), C_BR};
        tbl[8]  = '{"mstall_prio",    mk(1, 3,1, 0,0, 3,1,1, 0,0, 1, 1,0), C_MST};
        tbl[9]  = '{"mem_done",       mk(0, 0,0, 0,0, 0,0,0, 0,0, 0, 1,1), C_NONE};
        tbl[10] = '{"exe_wb0",        mk(1, 4,1, 4,1, 4,0,1, 4,0, 0, 0,0), C_NONE};
        tbl[11] = '{"nofwd_src2_exe", mk(0, 1,1, 6,1, 6,1,0, 0,0, 0, 0,0), C_HAZ};

        // reset: outputs low although stall/hazard inputs are active
        rst_n = 1'b0;
        drive(tbl[8].in);
        model_reset();
        #7;
        chk("reset_ctrl", 64'(dut_ctrl), 64'(C_NONE));
        chk("reset_stats", 64'(dut_stats), 64'd0);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // table vectors
        for (int i = 0; i < 12; i++) begin
            run_cycle(tbl[i].in, tbl[i].exp, tbl[i].name);
        end
        run_cycle(clr_v, C_NONE, "clr_after_table");

        // load-use stalls exactly once and counts one hazard cycle
        run_cycle(tbl[0].in, C_HAZ, "lu_stall");
        run_cycle(tbl[1].in, C_NONE, "lu_release");
        chk("lu_hazard_cycles", 64'(hif.hazard_cycles), 64'd1);

        // branch with load-use: only flush, counted once
        run_cycle(clr_v, C_NONE, "clr_br");
        run_cycle(tbl[7].in, C_BR, "br_hazard");
        run_cycle(idle, C_NONE, "br_after");
        chk("br_flush_count", 64'(hif.flush_count), 64'd1);
        chk("br_hazard_cycles", 64'(hif.hazard_cycles), 64'd0);

        // 4-cycle memory stall with a branch held in EXE
        run_cycle(clr_v, C_NONE, "clr_mem");
        v = stall; v.br = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle(v, C_MST, "mstall_br");
        v.rdy = 1'b1;
        run_cycle(v, C_BR, "mstall_release");
        run_cycle(idle, C_NONE, "mstall_after");
        chk("mstall_wait_cycles", 64'(hif.mem_wait_cycles), 64'd4);
        chk("mstall_flush_count", 64'(hif.flush_count), 64'd1);
        chk("mstall_mem_err", 64'(hif.mem_err), 64'd1);

        // timeout: mem_err after the TO-th wait cycle, freeze persists
        run_cycle(clr_v, C_NONE, "clr_to");
        chk("to_err_cleared", 64'(hif.mem_err), 64'd0);
        for (int i = 0; i < TO; i++) run_cycle(stall, C_MST, "to_wait");
        chk("to_err_early", 64'(hif.mem_err), 64'd0);
        run_cycle(stall, C_MST, "to_wait_last");
        chk("to_err_set", 64'(hif.mem_err), 64'd1);
        for (int i = 0; i < 3; i++) run_cycle(stall, C_MST, "to_hold");
        run_cycle(idle, C_NONE, "to_abandon");
        chk("to_err_sticky", 64'(hif.mem_err), 64'd1);
        run_cycle(clr_v, C_NONE, "to_clr");
        chk("to_clr_stats", 64'(dut_stats), 64'd0);

        // reset in the middle of a memory wait
        for (int i = 0; i < 3; i++) run_cycle(stall, C_MST, "rst_pre");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'(dut_ctrl), 64'(C_NONE));
        chk("rst_mid_stats", 64'(dut_stats), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_cycle(idle, C_NONE, "rst_after");
        // FSM restarted in RUN: a 3-cycle stall must not reach timeout
        for (int i = 0; i < 3; i++) run_cycle(stall, C_MST, "rst_stall");
        v = stall; v.rdy = 1'b1;
        run_cycle(v, C_NONE, "rst_stall_done");
        chk("rst_no_err", 64'(hif.mem_err), 64'd0);
        chk("rst_wait_cycles", 64'(hif.mem_wait_cycles), 64'd3);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            v.fwd_en   = 1'($urandom_range(0, 1));
            v.src1     = 4'($urandom_range(0, 3));
            v.use1     = 1'($urandom_range(0, 1));
            v.src2     = 4'($urandom_range(0, 3));
            v.use2     = 1'($urandom_range(0, 1));
            v.exe_dest = 4'($urandom_range(0, 3));
            v.exe_wb   = 1'($urandom_range(0, 1));
            v.exe_rd   = 1'($urandom_range(0, 1));
            v.mem_dest = 4'($urandom_range(0, 3));
            v.mem_wb   = 1'($urandom_range(0, 1));
            v.br       = ($urandom_range(0, 6) == 0);
            v.req      = ($urandom_range(0, 2) == 0);
            v.rdy      = ($urandom_range(0, 2) == 0);
            v.clr      = ($urandom_range(0, 79) == 0);
            run_model(v, "rand");
        end
        run_model(idle, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the five-stage ARM pipeline. It watches the instruction in ID, the EXE and MEM stage destinations, the EXE branch decision and the data-memory handshake. From these it drives the `freeze`/`flush` controls of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers. It also keeps saturating stall statistics and a sticky memory-timeout flag.

## Interface
- `REG_ADDR_W`, 4: register-file address width.
- `CNT_W`, 16: width of each statistics counter.
- `MEM_TIMEOUT`, 255: MEM_WAIT cycles after which `mem_err` is set (≥1).

- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fwd_en`  in  1  1 = forwarding unit present; only load-use hazards stall.
- `id_src_1`, `id_src_2`  in  `REG_ADDR_W`  ID-stage source registers.
- `id_use_src_1`, `id_use_src_2`  in  1  source actually read by the ID instruction.
- `exe_dest`  in  `REG_ADDR_W`  destination in EXE (ID/EXE register output).
- `exe_wb_en`, `exe_mem_r_en`  in  1  EXE write-back enable, EXE load.
- `mem_dest`  in  `REG_ADDR_W`  destination in MEM.
- `mem_wb_en`  in  1  MEM write-back enable.
- `branch_taken`  in  1  EXE-stage taken branch.
- `mem_req`  in  1  MEM-stage load/store in progress.
- `mem_ready`  in  1  data memory completes the MEM-stage access this cycle.
- `clr_stats`  in  1  synchronous clear of counters and `mem_err`.
- `pc_freeze`, `if_freeze`, `id_freeze`, `exe_freeze`, `mem_freeze`  out  1  hold the corresponding stage register.
- `if_flush`, `id_flush`  out  1  clear the IF/ID and ID/EXE stage registers.
- `hazard`  out  1  data hazard currently stalling.
- `hazard_cycles`, `mem_wait_cycles`, `flush_count`  out  `CNT_W`  saturating statistics.
- `mem_err`  out  1  sticky: a memory wait exceeded `MEM_TIMEOUT`.

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when `mem_req & ~mem_ready`.
  - MEM_WAIT → RUN when `mem_ready`.
  - `mem_req` low while in MEM_WAIT also returns to RUN (abandoned access).
- `mstall = mem_req & ~mem_ready`. This is evaluated combinationally in both states.
- Data hazard, checked per source with `id_use_src_n` set:
  - `fwd_en=0`: hazard if the source equals `exe_dest` with `exe_wb_en`, or equals `mem_dest` with `mem_wb_en`.
  - `fwd_en=1`: hazard only if the source equals `exe_dest` with `exe_wb_en & exe_mem_r_en`.
  - A matching destination with its write-back enable low never causes a hazard.
- Priority, highest first:
  1. `mstall`: all five freezes = 1; `if_flush = id_flush = 0`, because a flush would override the held register.
  2. `branch_taken`: `if_flush = id_flush = 1`; no freezes; `hazard = 0`, since the ID instruction is discarded anyway.
  3. Data hazard: `pc_freeze = if_freeze = 1`, `id_flush = 1` (bubble into ID/EXE); `hazard = 1`.
  4. Otherwise all outputs are 0.
- If `branch_taken` arrives during `mstall`, the branch stays held in EXE. The flush is issued in the first cycle `mstall` drops.
- Counters saturate at all-ones and never wrap:
  - `hazard_cycles` +1 per cycle with `hazard` = 1.
  - `mem_wait_cycles` +1 per cycle with `mstall` = 1.
  - `flush_count` +1 per cycle with `if_flush` = 1.
- Wait counter: an internal count of consecutive MEM_WAIT cycles, cleared on leaving MEM_WAIT. When it reaches `MEM_TIMEOUT`, `mem_err` sets and stays set. The freeze continues regardless; recovery is by reset.
- `clr_stats` zeroes the three counters and `mem_err` on the next edge and takes precedence over any same-cycle increment.

## Timing
- Reset (`rst` = 0): state RUN; counters, wait counter and `mem_err` = 0. All freeze/flush/`hazard` outputs are forced to 0 while reset is asserted, independent of the inputs.
- Freeze, flush and `hazard` are combinational from the current inputs and state, with zero-cycle latency. Stage registers act on them at the same rising edge.
- Counters and `mem_err` are registered and update one edge after the causing condition.
- A load-use hazard stalls exactly one cycle. A `fwd_en=0` hazard stalls until both the EXE and MEM matches have retired (≤2 cycles).
- Reset mid-MEM_WAIT returns the FSM to RUN immediately, asynchronously.

## Test plan
- **Load-use hazard:** `fwd_en=1`, ID reads r3 (`id_use_src_1`), EXE `exe_dest`=3 with `exe_wb_en=1`, `exe_mem_r_en=1` → one cycle of `pc_freeze=if_freeze=id_flush=hazard=1`; `hazard_cycles`=1. The same case with `exe_mem_r_en=0` → no stall.
- **No forwarding:** `fwd_en=0`, `mem_dest`=5 with `mem_wb_en=1`, `id_src_2`=5, `id_use_src_2=1` → hazard. With `id_use_src_2=0` → no hazard. With `mem_wb_en=0` → no hazard.
- **Branch priority:** `branch_taken=1` together with a load-use hazard → `if_flush=id_flush=1`, `hazard=0`, no freezes; `flush_count`=1.
- **Memory stall:** `mem_req=1`, `mem_ready=0` for 4 cycles, then 1 → all freezes high for 4 cycles, state back to RUN; `mem_wait_cycles`=4. `branch_taken` held throughout → flush appears only in the release cycle.
- **Timeout:** `MEM_TIMEOUT`=3, `mem_ready` held 0 → `mem_err`=1 after the 3rd MEM_WAIT cycle, freezes stay high. `clr_stats` → `mem_err`=0 and counters 0.
- **Reset mid-operation:** assert `rst`=0 during MEM_WAIT → outputs 0 immediately; after release, state RUN and counters 0.
